multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the 16-bit CPU datapath (pc, rom/IR, register_file, alu, extsign, main_memory, mux2to1 x2).

---
 rtl/cpu_ctrl_pkg.sv | 55 +++++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: opcodes, FSM states,
// instruction classes and ALU function codes, plus small decode helpers.
package cpu_ctrl_pkg;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpAddi = 4'h5;
  localparam logic [3:0] OpLd   = 4'h6;
  localparam logic [3:0] OpSt   = 4'h7;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  typedef enum logic [3:0] {
    ClsNop, ClsAdd, ClsSub, ClsAnd, ClsOr, ClsAddi, ClsLd, ClsSt, ClsHalt, ClsIllegal
  } cls_e;

  function automatic cls_e decode_op(logic [3:0] op);
    case (op)
      OpNop:   return ClsNop;
      OpAdd:   return ClsAdd;
      OpSub:   return ClsSub;
      OpAnd:   return ClsAnd;
      OpOr:    return ClsOr;
      OpAddi:  return ClsAddi;
      OpLd:    return ClsLd;
      OpSt:    return ClsSt;
      OpHalt:  return ClsHalt;
      default: return ClsIllegal;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(cls_e cls);
    case (cls)
      ClsSub:  return AluSub;
      ClsAnd:  return AluAnd;
      ClsOr:   return AluOr;
      default: return AluAdd;
    endcase
  endfunction

  // Classes that take their second ALU operand from the sign extender.
  function automatic logic uses_imm(cls_e cls);
    return (cls == ClsAddi) || (cls == ClsLd) || (cls == ClsSt);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags when the wait limit is reached.
module mem_wait_timer #(
  parameter int unsigned Limit = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned Width = $clog2(Limit + 1);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == Width'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with a waited memory
// handshake, retired-instruction counter and illegal/timeout flags.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [3:0]          op_code,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                ir_ld,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                sel1,
  output logic                e_rd_en,
  output logic                m_rd_en,
  output logic                m_wr_en,
  output logic                sel2,
  output logic                rf_wr_en,
  output logic                halted,
  output logic                illegal,
  output logic                mem_err,
  output logic [CNT_W-1:0]    retired
);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  cls_e             op_cls;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             wait_expired;

  assign op_cls  = decode_op(op_code);
  assign retired = retired_q;

  mem_wait_timer #(
    .Limit (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (state_q != StMem),
    .en_i      (state_q == StMem),
    .expired_o (wait_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsNop;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch: if (run) state_d = StDecode;
      StDecode: begin
        cls_d = op_cls;
        if (op_cls == ClsHalt) begin
          state_d = StHalt;
          retire  = 1'b1;
        end else if (op_cls == ClsIllegal) begin
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (cls_q == ClsNop) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (cls_q == ClsLd || cls_q == ClsSt) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        // A ready in the same cycle as the timeout still completes the access.
        if (mem_ready) begin
          if (cls_q == ClsSt) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end else if (wait_expired) begin
          state_d = StFetch;
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_comb begin
    pc_en    = 1'b0;
    ir_ld    = 1'b0;
    alu_op   = '0;
    sel1     = 1'b0;
    e_rd_en  = 1'b0;
    m_rd_en  = 1'b0;
    m_wr_en  = 1'b0;
    sel2     = 1'b0;
    rf_wr_en = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    if (state_q == StExec || state_q == StMem || state_q == StWb) begin
      alu_op  = ALU_OP_W'(alu_of(cls_q));
      sel1    = uses_imm(cls_q);
      e_rd_en = uses_imm(cls_q);
    end
    unique case (state_q)
      StFetch: begin
        // Fetch strobes are gated by rst so nothing fires while reset is held.
        pc_en = run && rst;
        ir_ld = run && rst;
      end
      StDecode: illegal = (op_cls == ClsIllegal);
      StMem: begin
        m_rd_en = (cls_q == ClsLd);
        m_wr_en = (cls_q == ClsSt);
        mem_err = wait_expired && !mem_ready;
      end
      StWb: begin
        rf_wr_en = 1'b1;
        sel2     = (cls_q == ClsLd);
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// corner sequences, and randomized instruction streams against a schedule model.
module tb_multicycle_ctrl;

  localparam int Tmo = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b1;
  logic [3:0]  op_code = 4'h0;
  logic        mem_ready = 1'b0;
  logic        pc_en, ir_ld, sel1, e_rd_en, m_rd_en, m_wr_en, sel2, rf_wr_en;
  logic        halted, illegal, mem_err;
  logic [2:0]  alu_op;
  logic [15:0] retired;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ret = 0;

  multicycle_ctrl #(
    .ALU_OP_W    (3),
    .MEM_TIMEOUT (Tmo),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .op_code   (op_code),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .ir_ld     (ir_ld),
    .alu_op    (alu_op),
    .sel1      (sel1),
    .e_rd_en   (e_rd_en),
    .m_rd_en   (m_rd_en),
    .m_wr_en   (m_wr_en),
    .sel2      (sel2),
    .rf_wr_en  (rf_wr_en),
    .halted    (halted),
    .illegal   (illegal),
    .mem_err   (mem_err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // One cycle: inputs to drive, expected outputs
  // {pc_en, ir_ld, alu_op[2:0], sel1, e_rd_en, m_rd_en, m_wr_en, sel2, rf_wr_en, halted,
  //  illegal, mem_err}, and whether an instruction retires at the end of the cycle.
  typedef struct {
    bit          run;
    logic [3:0]  op;
    bit          rdy;
    logic [13:0] exp;
    bit          inc;
  } rec_t;

  rec_t q[$];
  rec_t tbl[12];

  function automatic rec_t mk(input bit rn, input logic [3:0] op, input bit rdy, input bit pc,
                              input bit ir, input logic [2:0] alu, input bit s1, input bit e,
                              input bit mr, input bit mw, input bit s2, input bit rf,
                              input bit h, input bit il, input bit me, input bit inc);
    rec_t r;
    r.run = rn;
    r.op  = op;
    r.rdy = rdy;
    r.exp = {pc, ir, alu, s1, e, mr, mw, s2, rf, h, il, me};
    r.inc = inc;
    return r;
  endfunction

  function automatic logic [13:0] outs();
    return {pc_en, ir_ld, alu_op, sel1, e_rd_en, m_rd_en, m_wr_en, sel2, rf_wr_en, halted,
            illegal, mem_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
  endtask

  task automatic apply(input rec_t r, input string nm);
    @(negedge clk);
    run = r.run;
    op_code = r.op;
    mem_ready = r.rdy;
    #1;
    chk({nm, " outputs"}, 32'(outs()), 32'(r.exp));
    chk({nm, " retired"}, 32'(retired), 32'(exp_ret[15:0]));
    exp_ret += int'(r.inc);
  endtask

  task automatic run_q(input string nm);
    while (q.size() > 0) apply(q.pop_front(), nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    #1;
    chk("reset outputs", 32'(outs()), 32'd0);
    chk("reset retired", 32'(retired), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_ret = 0;
  endtask

  // Expected per-cycle schedule of one instruction with run=1, derived from the
  // latency rules: F, D, then E / MEM x(W+1) / WB as the opcode requires.
  task automatic build(input logic [3:0] op, input int w, input bit tmo);
    logic [2:0] a;
    bit         s, ls, last;
    int         n;
    a  = (op == 4'h2) ? 3'b001 : (op == 4'h3) ? 3'b010 : (op == 4'h4) ? 3'b011 : 3'b000;
    s  = (op >= 4'h5 && op <= 4'h7);
    ls = (op == 4'h6 || op == 4'h7);
    q.push_back(mk(1, op, 1'($urandom_range(0, 1)), 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (op >= 4'h8 && op <= 4'hE) begin
      q.push_back(mk(1, op, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      return;
    end
    if (op == 4'hF) begin
      q.push_back(mk(1, op, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      return;
    end
    q.push_back(mk(1, op, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, op, 1'($urandom_range(0, 1)), 0, 0, a, s, s, 0, 0, 0, 0, 0, 0, 0,
                   op == 4'h0));
    if (op == 4'h0) return;
    if (ls) begin
      n = tmo ? Tmo : w;
      for (int k = 0; k <= n; k++) begin
        last = (k == n);
        q.push_back(mk(1, op, !tmo && last, 0, 0, a, s, s, op == 4'h6, op == 4'h7, 0, 0, 0, 0,
                       tmo && last, op == 4'h7 && !tmo && last));
      end
      if (tmo || op == 4'h7) return;
    end
    q.push_back(mk(1, op, 1'($urandom_range(0, 1)), 0, 0, a, s, s, 0, 0, op == 4'h6, 1, 0, 0, 0,
                   1));
  endtask

  initial begin
    // ADD then LD with 3 wait cycles, written out cycle by cycle.
    tbl[0]  = mk(1, 4'h1, 0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 4'h1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 4'h1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 4'h1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[4]  = mk(1, 4'h6, 0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 4'h6, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 4'h6, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 4'h6, 0, 0, 0, 3'b000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 4'h6, 0, 0, 0, 3'b000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 4'h6, 0, 0, 0, 3'b000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 4'h6, 1, 0, 0, 3'b000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 4'h6, 0, 0, 0, 3'b000, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Random instruction stream with occasional FETCH stalls.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      int         stall;
      if ($urandom_range(0, 3) == 0) begin
        stall = $urandom_range(1, 3);
        for (int k = 0; k < stall; k++)
          q.push_back(mk(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 14)) : 4'($urandom_range(0, 7));
      build(op, $urandom_range(0, Tmo), $urandom_range(0, 7) == 0);
      run_q("rand");
    end

    // ST with no ready: mem_err on the 16th MEM cycle, not retired.
    build(4'h7, 0, 1);
    run_q("st_timeout");

    // run drops during EXEC of SUB: it still writes back, then FETCH stalls.
    build(4'h2, 0, 0);
    for (int k = 2; k < q.size(); k++) q[k].run = 0;
    for (int k = 0; k < 3; k++) q.push_back(mk(0, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_q("sub_run0");

    build(4'h9, 0, 0);
    run_q("illegal");

    // HALT is sticky regardless of run.
    build(4'hF, 0, 0);
    for (int k = 0; k < 6; k++)
      q.push_back(mk(1'(k % 2), 4'h0, 1'(k % 2), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    run_q("halt");

    do_reset();
    build(4'h1, 0, 0);
    run_q("add_after_halt");

    // Asynchronous reset in the middle of a ST wait.
    build(4'h7, 10, 0);
    for (int k = 0; k < 5; k++) apply(q.pop_front(), "st_pre_reset");
    q.delete();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_st m_wr_en", 32'(m_wr_en), 32'd0);
    chk("rst_mid_st outputs", 32'(outs()), 32'd0);
    chk("rst_mid_st retired", 32'(retired), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_ret = 0;
    build(4'h0, 0, 0);
    run_q("nop_after_rst");
    apply(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
